// File: rtl/commit_trace_fifo_if.sv
// Output stream of the commit trace FIFO.
//   master : driven by the FIFO (OutValid, OutPC, OutRD, OutData), samples OutReady
//   slave  : the host/debug sink, drives OutReady
// The head entry is shown ahead: OutValid and the payload are valid whenever
// the FIFO is non-empty, and an entry is consumed on a clock edge where
// OutValid && OutReady.
interface commit_trace_fifo_if;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] OutPC;
    logic [4:0]  OutRD;
    logic [31:0] OutData;

    modport master (
        output OutValid,
        output OutPC,
        output OutRD,
        output OutData,
        input  OutReady
    );

    modport slave (
        input  OutValid,
        input  OutPC,
        input  OutRD,
        input  OutData,
        output OutReady
    );
endinterface

// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo
// Captures every retired register write of the mips core {PC, RD, WData}
// into an on-chip FIFO and drains it to a host/debug sink over a valid/ready
// stream. Writes to R0 are never traced. When the FIFO is full a capture is
// either dropped and counted (STOP_ON_FULL=0) or freezes capture until Flush
// (STOP_ON_FULL=1).
// Ports:
//   Clk, Reset        clock (rising edge), asynchronous active-high reset
//   PC, RegWr, RD,    core register-writeback port
//   WData
//   TraceEn           level: arms (1) / disarms (0) capture
//   Flush             synchronous clear of FIFO, drop counter, Overflow, Stopped
//   out_if            show-ahead output stream (commit_trace_fifo_if.master)
//   Count             entries currently held (0..DEPTH)
//   DropCnt           captures lost to a full FIFO, saturating
//   Overflow          sticky: a capture was dropped since reset/Flush
//   Stopped           capture frozen after a full-FIFO drop (STOP_ON_FULL=1)
module commit_trace_fifo #(
    parameter int DEPTH        = 16,
    parameter bit STOP_ON_FULL = 1'b0,
    parameter int CNT_W        = 16
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [31:0]              PC,
    input  logic                     RegWr,
    input  logic [4:0]               RD,
    input  logic [31:0]              WData,
    input  logic                     TraceEn,
    input  logic                     Flush,
    commit_trace_fifo_if.master      out_if,
    output logic [$clog2(DEPTH):0]   Count,
    output logic [CNT_W-1:0]         DropCnt,
    output logic                     Overflow,
    output logic                     Stopped
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        s_off,
        s_on,
        s_stopped
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    state_e        state;
    state_e        state_nxt;
    logic          empty;
    logic          full;
    logic          capture;
    logic          push;
    logic          pop;
    logic          drop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // without a separate occupancy register.
    assign Count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign capture = RegWr && (RD != 5'd0) && (state == s_on);
    assign pop     = !Flush && !empty && out_if.OutReady;
    // A pop on the same edge frees a slot, so a capture into a full FIFO is
    // still accepted when the sink is draining.
    assign push    = !Flush && capture && (!full || pop);
    assign drop    = !Flush && capture && full && !pop;

    assign Stopped = (state == s_stopped);

    // FSM state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= s_off;
        end else begin
            // NOTE: sequential state is always assigned with <= so every
            // register samples pre-edge values regardless of block order.
            state <= state_nxt;
        end
    end

    // FSM next-state logic; Flush overrides every transition.
    always_comb begin
        // NOTE: default assigned first so no path through the case leaves
        // state_nxt unassigned, which would infer a latch.
        state_nxt = state;
        if (Flush) begin
            state_nxt = s_off;
        end else begin
            case (state)
                s_off:     if (TraceEn) state_nxt = s_on;
                s_on: begin
                    if (!TraceEn)
                        state_nxt = s_off;
                    else if (drop && STOP_ON_FULL)
                        state_nxt = s_stopped;
                end
                s_stopped: state_nxt = s_stopped;
                default:   state_nxt = s_off;
            endcase
        end
    end

    // Pointers, drop counter and sticky overflow flag.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            DropCnt  <= '0;
            Overflow <= 1'b0;
        end else if (Flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            DropCnt  <= '0;
            Overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (drop) begin
                Overflow <= 1'b1;
                if (DropCnt != '1)
                    DropCnt <= DropCnt + CNT_W'(1);
            end
        end
    end

    // NOTE: the storage array has no reset; its contents are only visible
    // through the pointers, which are reset, and the outputs are masked
    // while empty.
    always_ff @(posedge Clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= '{pc: PC, rd: RD, data: WData};
    end

    // Show-ahead head entry; forced to zero while empty so that an
    // asynchronous reset clears the outputs without waiting for a clock.
    assign head            = mem[rd_ptr[AW-1:0]];
    assign out_if.OutValid = !empty;
    assign out_if.OutPC    = empty ? 32'd0 : head.pc;
    assign out_if.OutRD    = empty ? 5'd0  : head.rd;
    assign out_if.OutData  = empty ? 32'd0 : head.data;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Self-checking bench for commit_trace_fifo.
// dut_a runs with STOP_ON_FULL=0 (drop and count), dut_b with STOP_ON_FULL=1.
// Both share the core writeback inputs and reset; each has its own TraceEn,
// Flush and sink.
module tb_commit_trace_fifo;

    logic        Clk;
    logic        Reset;
    logic [31:0] PC;
    logic        RegWr;
    logic [4:0]  RD;
    logic [31:0] WData;
    logic        trace_en_a, flush_a;
    logic        trace_en_b, flush_b;
    logic [4:0]  count_a, count_b;
    logic [15:0] drop_cnt_a, drop_cnt_b;
    logic        overflow_a, overflow_b;
    logic        stopped_a, stopped_b;

    int checks;
    int failures;

    commit_trace_fifo_if if_a ();
    commit_trace_fifo_if if_b ();

    commit_trace_fifo #(.DEPTH(16), .STOP_ON_FULL(1'b0), .CNT_W(16)) dut_a (
        .Clk      (Clk),
        .Reset    (Reset),
        .PC       (PC),
        .RegWr    (RegWr),
        .RD       (RD),
        .WData    (WData),
        .TraceEn  (trace_en_a),
        .Flush    (flush_a),
        .out_if   (if_a.master),
        .Count    (count_a),
        .DropCnt  (drop_cnt_a),
        .Overflow (overflow_a),
        .Stopped  (stopped_a)
    );

    commit_trace_fifo #(.DEPTH(16), .STOP_ON_FULL(1'b1), .CNT_W(16)) dut_b (
        .Clk      (Clk),
        .Reset    (Reset),
        .PC       (PC),
        .RegWr    (RegWr),
        .RD       (RD),
        .WData    (WData),
        .TraceEn  (trace_en_b),
        .Flush    (flush_b),
        .out_if   (if_b.master),
        .Count    (count_b),
        .DropCnt  (drop_cnt_b),
        .Overflow (overflow_b),
        .Stopped  (stopped_b)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic        te;
        logic        regwr;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic        ready;
        logic        exp_valid;
        int          exp_count;
        logic [31:0] exp_pc;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic core_write(input logic [4:0] rd, input logic [31:0] data, input logic [31:0] pc);
        RegWr = 1'b1;
        RD    = rd;
        WData = data;
        PC    = pc;
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] exp_data;

        checks     = 0;
        failures   = 0;
        Reset      = 1'b1;
        PC         = '0;
        RegWr      = 1'b0;
        RD         = '0;
        WData      = '0;
        trace_en_a = 1'b0;
        flush_a    = 1'b0;
        trace_en_b = 1'b0;
        flush_b    = 1'b0;
        if_a.OutReady = 1'b0;
        if_b.OutReady = 1'b0;

        //                 te    wr    rd     wdata          pc          rdy   valid cnt  pc          rd     data
        vecs[0]  = '{1'b1, 1'b1, 5'd0,  32'hdeadbeef, 32'h2ffc, 1'b0, 1'b0, 0, 32'h0,    5'd0,  32'h0};
        vecs[1]  = '{1'b1, 1'b1, 5'd8,  32'h3c10ffff, 32'h3000, 1'b0, 1'b1, 1, 32'h3000, 5'd8,  32'h3c10ffff};
        vecs[2]  = '{1'b1, 1'b0, 5'd0,  32'h0,        32'h0,    1'b0, 1'b1, 1, 32'h3000, 5'd8,  32'h3c10ffff};
        vecs[3]  = '{1'b1, 1'b1, 5'd9,  32'h11,       32'h3004, 1'b0, 1'b1, 2, 32'h3000, 5'd8,  32'h3c10ffff};
        vecs[4]  = '{1'b1, 1'b1, 5'd10, 32'h22,       32'h3008, 1'b1, 1'b1, 2, 32'h3004, 5'd9,  32'h11};
        vecs[5]  = '{1'b1, 1'b0, 5'd0,  32'h0,        32'h0,    1'b1, 1'b1, 1, 32'h3008, 5'd10, 32'h22};
        vecs[6]  = '{1'b1, 1'b0, 5'd0,  32'h0,        32'h0,    1'b1, 1'b0, 0, 32'h0,    5'd0,  32'h0};
        vecs[7]  = '{1'b1, 1'b0, 5'd0,  32'h0,        32'h0,    1'b1, 1'b0, 0, 32'h0,    5'd0,  32'h0};
        vecs[8]  = '{1'b1, 1'b1, 5'd3,  32'h33,       32'h300c, 1'b1, 1'b1, 1, 32'h300c, 5'd3,  32'h33};
        vecs[9]  = '{1'b1, 1'b0, 5'd0,  32'h0,        32'h0,    1'b1, 1'b0, 0, 32'h0,    5'd0,  32'h0};
        vecs[10] = '{1'b0, 1'b0, 5'd0,  32'h0,        32'h0,    1'b0, 1'b0, 0, 32'h0,    5'd0,  32'h0};
        vecs[11] = '{1'b0, 1'b1, 5'd5,  32'h55,       32'h3010, 1'b0, 1'b0, 0, 32'h0,    5'd0,  32'h0};
        vecs[12] = '{1'b1, 1'b1, 5'd6,  32'h66,       32'h3014, 1'b0, 1'b0, 0, 32'h0,    5'd0,  32'h0};
        vecs[13] = '{1'b1, 1'b1, 5'd7,  32'h77,       32'h3018, 1'b0, 1'b1, 1, 32'h3018, 5'd7,  32'h77};
        vecs[14] = '{1'b1, 1'b0, 5'd0,  32'h0,        32'h0,    1'b1, 1'b0, 0, 32'h0,    5'd0,  32'h0};

        // 1: reset state
        #12;
        Reset = 1'b0;
        #1;
        check("rst_valid",    32'(if_a.OutValid), 32'd0);
        check("rst_count",    32'(count_a),       32'd0);
        check("rst_dropcnt",  32'(drop_cnt_a),    32'd0);
        check("rst_overflow", 32'(overflow_a),    32'd0);
        check("rst_stopped",  32'(stopped_a),     32'd0);
        check("rst_outpc",    if_a.OutPC,         32'd0);
        step();
        step();
        check("idle_count",   32'(count_a),       32'd0);
        check("idle_valid",   32'(if_a.OutValid), 32'd0);

        // 2: arm, then table of single-cycle vectors on dut_a
        trace_en_a = 1'b1;
        step();
        for (int i = 0; i < 15; i++) begin
            trace_en_a    = vecs[i].te;
            RegWr         = vecs[i].regwr;
            RD            = vecs[i].rd;
            WData         = vecs[i].wdata;
            PC            = vecs[i].pc;
            if_a.OutReady = vecs[i].ready;
            step();
            check($sformatf("vec%0d_valid", i), 32'(if_a.OutValid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_count", i), 32'(count_a),       32'(vecs[i].exp_count));
            check($sformatf("vec%0d_pc",    i), if_a.OutPC,         vecs[i].exp_pc);
            check($sformatf("vec%0d_rd",    i), 32'(if_a.OutRD),    32'(vecs[i].exp_rd));
            check($sformatf("vec%0d_data",  i), if_a.OutData,       vecs[i].exp_data);
        end
        RegWr = 1'b0;

        // 3: 20 writes with the sink stalled -> 16 held, 4 dropped
        if_a.OutReady = 1'b0;
        for (int i = 0; i < 20; i++) begin
            core_write(5'((i % 31) + 1), 32'h1000 + 32'(i), 32'h4000 + 32'(4 * i));
            step();
            if (i == 15) begin
                check("fill16_count",   32'(count_a),    32'd16);
                check("fill16_dropcnt", 32'(drop_cnt_a), 32'd0);
                check("fill16_ovf",     32'(overflow_a), 32'd0);
            end
        end
        RegWr = 1'b0;
        check("full_count",    32'(count_a),    32'd16);
        check("full_dropcnt",  32'(drop_cnt_a), 32'd4);
        check("full_overflow", 32'(overflow_a), 32'd1);
        check("full_stopped",  32'(stopped_a),  32'd0);
        check("full_head_pc",  if_a.OutPC,      32'h4000);

        // 4: full FIFO, push and pop on the same edge
        core_write(5'd20, 32'h0000abcd, 32'h5000);
        if_a.OutReady = 1'b1;
        step();
        RegWr = 1'b0;
        check("pp_full_count",   32'(count_a),    32'd16);
        check("pp_full_dropcnt", 32'(drop_cnt_a), 32'd4);
        for (int k = 0; k < 16; k++) begin
            exp_pc   = (k < 15) ? 32'h4000 + 32'(4 * (k + 1)) : 32'h5000;
            exp_data = (k < 15) ? 32'h1000 + 32'(k + 1)       : 32'h0000abcd;
            check($sformatf("drain%0d_pc",   k), if_a.OutPC,   exp_pc);
            check($sformatf("drain%0d_data", k), if_a.OutData, exp_data);
            step();
        end
        check("drained_count", 32'(count_a),       32'd0);
        check("drained_valid", 32'(if_a.OutValid), 32'd0);

        // Flush with a capture and a pop requested on the same edge
        if_a.OutReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            core_write(5'd4, 32'h7000 + 32'(i), 32'h6000 + 32'(4 * i));
            step();
        end
        check("preflush_count", 32'(count_a), 32'd3);
        flush_a       = 1'b1;
        if_a.OutReady = 1'b1;
        core_write(5'd4, 32'h7777, 32'h6100);
        step();
        flush_a = 1'b0;
        check("flush_count",    32'(count_a),       32'd0);
        check("flush_valid",    32'(if_a.OutValid), 32'd0);
        check("flush_dropcnt",  32'(drop_cnt_a),    32'd0);
        check("flush_overflow", 32'(overflow_a),    32'd0);
        if_a.OutReady = 1'b0;
        step();
        check("postflush_off_count", 32'(count_a), 32'd0);
        step();
        check("rearm_count", 32'(count_a), 32'd1);
        check("rearm_pc",    if_a.OutPC,   32'h6100);
        RegWr         = 1'b0;
        trace_en_a    = 1'b0;
        if_a.OutReady = 1'b1;
        step();
        if_a.OutReady = 1'b0;

        // 5: STOP_ON_FULL=1 on dut_b
        trace_en_b = 1'b1;
        step();
        for (int i = 0; i < 17; i++) begin
            core_write(5'd12, 32'h8000 + 32'(i), 32'h9000 + 32'(4 * i));
            step();
            if (i == 15) begin
                check("b_fill16_count",   32'(count_b),   32'd16);
                check("b_fill16_stopped", 32'(stopped_b), 32'd0);
            end
        end
        check("b_stopped",  32'(stopped_b),  32'd1);
        check("b_dropcnt",  32'(drop_cnt_b), 32'd1);
        check("b_overflow", 32'(overflow_b), 32'd1);
        check("b_count",    32'(count_b),    32'd16);
        for (int i = 0; i < 3; i++) begin
            core_write(5'd13, 32'h8800 + 32'(i), 32'h9800);
            step();
        end
        check("b_ignored_dropcnt", 32'(drop_cnt_b), 32'd1);
        check("b_ignored_count",   32'(count_b),    32'd16);
        check("b_a_untouched",     32'(count_a),    32'd0);
        RegWr      = 1'b0;
        trace_en_b = 1'b0;
        step();
        check("b_te_ignored_stopped", 32'(stopped_b), 32'd1);
        trace_en_b = 1'b1;
        flush_b    = 1'b1;
        core_write(5'd14, 32'haaaa, 32'h9a00);
        step();
        flush_b = 1'b0;
        check("b_flush_count",    32'(count_b),    32'd0);
        check("b_flush_stopped",  32'(stopped_b),  32'd0);
        check("b_flush_dropcnt",  32'(drop_cnt_b), 32'd0);
        check("b_flush_overflow", 32'(overflow_b), 32'd0);
        step();
        check("b_off_count", 32'(count_b), 32'd0);
        step();
        check("b_rearm_count", 32'(count_b), 32'd1);
        check("b_rearm_data",  if_b.OutData, 32'haaaa);
        RegWr      = 1'b0;
        trace_en_b = 1'b0;

        // 6: asynchronous reset in the middle of a drain
        trace_en_a    = 1'b1;
        if_a.OutReady = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            core_write(5'd2, 32'hc000 + 32'(i), 32'hb000 + 32'(4 * i));
            step();
        end
        RegWr         = 1'b0;
        if_a.OutReady = 1'b1;
        step();
        check("middrain_count", 32'(count_a), 32'd5);
        check("middrain_pc",    if_a.OutPC,   32'hb004);
        #2;
        Reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(if_a.OutValid), 32'd0);
        check("async_rst_count", 32'(count_a),       32'd0);
        check("async_rst_pc",    if_a.OutPC,         32'd0);
        check("async_rst_rd",    32'(if_a.OutRD),    32'd0);
        check("async_rst_data",  if_a.OutData,       32'd0);
        check("async_rst_b_cnt", 32'(count_b),       32'd0);
        #2;
        Reset = 1'b0;
        step();
        check("post_rst_count", 32'(count_a),       32'd0);
        check("post_rst_valid", 32'(if_a.OutValid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
